uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among N_REQ byte-producing requesters using round-robin arbitration.
- Accepts one byte at a time per valid/ready handshake and drives the transmitter's txen and tx_data.
- Sequences each transfer by watching tx_ing, so the next byte launches only after the current frame finishes.
- Sits between on-chip producers (debug, log, command reply) and the UART core.

---
 rtl/uart_ctrl_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
// Optional build macro used by this slice: UART_TX_ARB_LOCK_EN.
package uart_ctrl_pkg;

  // Transfer sequencing states of the arbiter FSM.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Byte width of the UART core.
  localparam int UART_DATA_W = 8;

  // Default cycles allowed between txen and tx_ing rising.
  localparam int START_TIMEOUT_DEF = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and UART-side signals of the transmit arbiter.
// The slave modport is the arbiter; the master modport is the environment
// (byte producers plus UART core). Build macro: UART_TX_ARB_LOCK_EN adds
// the per-requester lock vector.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    txen_o;
  logic [DATA_W-1:0]       tx_data_o;
  logic                    tx_ing_i;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N_REQ-1:0]        req_lock_i;

  modport slave (
    input  req_valid_i, req_data_i, req_lock_i, tx_ing_i,
    output req_ready_o, txen_o, tx_data_o
  );

  modport master (
    output req_valid_i, req_data_i, req_lock_i, tx_ing_i,
    input  req_ready_o, txen_o, tx_data_o
  );
`else
  modport slave (
    input  req_valid_i, req_data_i, tx_ing_i,
    output req_ready_o, txen_o, tx_data_o
  );

  modport master (
    output req_valid_i, req_data_i, tx_ing_i,
    input  req_ready_o, txen_o, tx_data_o
  );
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request searching upward
// from last_ptr+1, wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any_req
);
  localparam int IDX_W = $clog2(N_REQ);

  int               idx;
  logic [IDX_W-1:0] idx_w;
  logic             found;

  assign any_req = |req;

  // Walk the N_REQ positions after the pointer and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx   = (int'(last_ptr) + off) % N_REQ;
      idx_w = idx[IDX_W-1:0];
      if (!found && req[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ producers.
// Each accepted byte is launched with a txen pulse and the block waits for
// the UART's tx_ing to rise and fall before serving the next requester.
// Build macro UART_TX_ARB_LOCK_EN adds packet locking (req_lock_i, lock_o).
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = UART_DATA_W,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                     clock_i,
  input  logic                     resetn_i,
  uart_tx_arbiter_if.slave         bus,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o,
  output logic                     start_err_o
`ifdef UART_TX_ARB_LOCK_EN
  ,
  output logic                     lock_o
`endif
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_t        state_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  grant_id_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic              txen_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [N_REQ-1:0]  grant_vec;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_req;
  logic              can_grant;
  logic [DATA_W-1:0] req_bytes [N_REQ];

  // Unpack the flat data bus into one byte per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = bus.req_data_i[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (bus.req_valid_i),
    .last_ptr  (ptr_reg),
    .grant     (grant_vec),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // A grant needs an idle FSM and an idle UART; reset also masks ready so
  // no producer sees a phantom accept while the block is held in reset.
  assign can_grant       = (state_reg == IDLE) && !bus.tx_ing_i && any_req && resetn_i;
  assign bus.req_ready_o = can_grant ? grant_vec : '0;

  assign bus.txen_o    = txen_reg;
  assign bus.tx_data_o = tx_data_reg;
  assign grant_id_o    = grant_id_reg;
  assign busy_o        = (state_reg != IDLE);
  assign start_err_o   = err_reg;

`ifdef UART_TX_ARB_LOCK_EN
  logic             lock_reg;
  logic             lock_hold;
  logic [IDX_W-1:0] ptr_hold;

  // A lock only counts while the locked requester still has a byte queued.
  assign lock_hold = bus.req_lock_i[grant_id_reg] & bus.req_valid_i[grant_id_reg];
  // Rewind the pointer one slot so the search starts at the locked requester.
  assign ptr_hold  = (grant_id_reg == '0) ? IDX_W'(N_REQ - 1) : grant_id_reg - 1'b1;
  assign lock_o    = lock_reg;
`endif

  // Transfer sequencer: grant, launch, wait for tx_ing rise, wait for fall.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg    <= IDLE;
      ptr_reg      <= IDX_W'(N_REQ - 1);
      grant_id_reg <= '0;
      tx_data_reg  <= '0;
      txen_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_reg     <= 1'b0;
`endif
    end else begin
      txen_reg <= 1'b0;
      err_reg  <= 1'b0;
      unique case (state_reg)
        IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
          if (lock_reg && !bus.req_valid_i[grant_id_reg]) begin
            lock_reg <= 1'b0;
            ptr_reg  <= grant_id_reg;
          end
`endif
          if (can_grant) begin
            tx_data_reg  <= req_bytes[grant_idx];
            grant_id_reg <= grant_idx;
            ptr_reg      <= grant_idx;
            txen_reg     <= 1'b1;
            state_reg    <= LAUNCH;
`ifdef UART_TX_ARB_LOCK_EN
            lock_reg     <= 1'b0;
`endif
          end
        end
        LAUNCH: begin
          cnt_reg   <= '0;
          state_reg <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_ing_i) begin
            state_reg <= WAIT_DONE;
          end else if (cnt_reg == CNT_W'(START_TIMEOUT - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            if (lock_hold) begin
              ptr_reg  <= ptr_hold;
              lock_reg <= 1'b1;
            end
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_ing_i) begin
            state_reg <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            if (lock_hold) begin
              ptr_reg  <= ptr_hold;
              lock_reg <= 1'b1;
            end
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART model driving tx_ing.
// Build macro UART_TX_ARB_LOCK_EN enables the packet-lock scenario.
module tb_uart_tx_arbiter;
  localparam int N_REQ         = 4;
  localparam int DATA_W        = 8;
  localparam int START_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       start_err;
`ifdef UART_TX_ARB_LOCK_EN
  logic       lock_w;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int model_auto = 0;
  int model_pend = 0;
  int model_hold = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clock_i     (clk),
    .resetn_i    (rst_n),
    .bus         (bus),
    .grant_id_o  (grant_id),
    .busy_o      (busy),
    .start_err_o (start_err)
`ifdef UART_TX_ARB_LOCK_EN
    ,
    .lock_o      (lock_w)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One clock; the UART model raises tx_ing two cycles after txen and
  // holds it three cycles when enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (model_auto != 0) begin
      if (model_pend > 0) begin
        model_pend--;
        if (model_pend == 0) begin
          bus.tx_ing_i = 1'b1;
          model_hold   = 3;
        end
      end else if (model_hold > 0) begin
        model_hold--;
        if (model_hold == 0) bus.tx_ing_i = 1'b0;
      end
      if (bus.txen_o) model_pend = 2;
    end
    #1;
  endtask

  task automatic wait_idle(input string tag, input logic [7:0] exp_data);
    int   n = 0;
    logic stable = 1'b1;
    while (busy && n < 100) begin
      if (bus.tx_data_o !== exp_data) stable = 1'b0;
      tick();
      n++;
    end
    check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_hold"}, {31'd0, stable}, 32'd1);
  endtask

  task automatic wait_txen(input string tag);
    int n = 0;
    while (!bus.txen_o && n < 60) begin
      tick();
      n++;
    end
    check_val({tag, "_txen"}, {31'd0, bus.txen_o}, 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_auto = 0; model_pend = 0; model_hold = 0;
    bus.tx_ing_i = 1'b0;
    bus.req_valid_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.tx_ing_i    = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    bus.req_lock_i  = '0;
`endif
    // Reset state, with a request present that must not be accepted.
    #12;
    bus.req_valid_i = 4'b0001;
    #1;
    check_val("rst_ready", {28'd0, bus.req_ready_o}, 32'h0);
    check_val("rst_txen", {31'd0, bus.txen_o}, 32'h0);
    check_val("rst_busy", {31'd0, busy}, 32'h0);
    check_val("rst_grant", {30'd0, grant_id}, 32'h0);
    check_val("rst_data", {24'd0, bus.tx_data_o}, 32'h0);
    check_val("rst_err", {31'd0, start_err}, 32'h0);
    bus.req_valid_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request.
    bus.req_data_i  = 32'h000000A5;
    bus.req_valid_i = 4'b0001;
    model_auto = 1;
    #1;
    check_val("t1_ready", {28'd0, bus.req_ready_o}, 32'h1);
    tick();
    check_val("t1_txen", {31'd0, bus.txen_o}, 32'h1);
    check_val("t1_data", {24'd0, bus.tx_data_o}, 32'hA5);
    check_val("t1_grant", {30'd0, grant_id}, 32'h0);
    check_val("t1_busy", {31'd0, busy}, 32'h1);
    check_val("t1_ready_off", {28'd0, bus.req_ready_o}, 32'h0);
    bus.req_valid_i = '0;
    tick();
    check_val("t1_txen_pulse", {31'd0, bus.txen_o}, 32'h0);
    wait_idle("t1", 8'hA5);

    // All four continuously valid after reset: order 0,1,2,3,0.
    apply_reset();
    model_auto = 1;
    bus.req_data_i  = 32'h13121110;
    bus.req_valid_i = 4'b1111;
    #1;
    check_val("t2_first_ready", {28'd0, bus.req_ready_o}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      wait_txen("t2");
      check_val("t2_grant", {30'd0, grant_id}, k % 4);
      check_val("t2_data", {24'd0, bus.tx_data_o}, 32'h10 + (k % 4));
      check_val("t2_no_overlap", {31'd0, bus.tx_ing_i}, 32'h0);
      if (k == 4) bus.req_valid_i = '0;
      else tick();
    end
    wait_idle("t2", 8'h10);

    // UART never responds: start error START_TIMEOUT+1 cycles after txen.
    model_auto = 0;
    bus.tx_ing_i = 1'b0;
    bus.req_data_i  = 32'h005A0000;
    bus.req_valid_i = 4'b0100;
    #1;
    check_val("t3_ready", {28'd0, bus.req_ready_o}, 32'h4);
    tick();
    check_val("t3_txen", {31'd0, bus.txen_o}, 32'h1);
    bus.req_valid_i = '0;
    n = 0;
    while (!start_err && n < 40) begin
      tick();
      n++;
    end
    check_val("t3_err_delay", n, START_TIMEOUT + 1);
    check_val("t3_back_idle", {31'd0, busy}, 32'h0);
    tick();
    check_val("t3_err_pulse", {31'd0, start_err}, 32'h0);
    model_auto = 1;
    bus.req_data_i  = 32'h00003C00;
    bus.req_valid_i = 4'b0010;
    #1;
    check_val("t3_next_ready", {28'd0, bus.req_ready_o}, 32'h2);
    tick();
    check_val("t3_next_data", {24'd0, bus.tx_data_o}, 32'h3C);
    check_val("t3_next_grant", {30'd0, grant_id}, 32'h1);
    bus.req_valid_i = '0;
    wait_idle("t3", 8'h3C);

    // UART busy from an external transmission blocks the grant.
    model_auto = 0;
    bus.tx_ing_i = 1'b1;
    bus.req_data_i  = 32'h00770000;
    bus.req_valid_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t4_blocked", {28'd0, bus.req_ready_o}, 32'h0);
    end
    bus.tx_ing_i = 1'b0;
    #1;
    check_val("t4_ready", {28'd0, bus.req_ready_o}, 32'h4);
    model_auto = 1;
    tick();
    check_val("t4_txen", {31'd0, bus.txen_o}, 32'h1);
    check_val("t4_grant", {30'd0, grant_id}, 32'h2);
    check_val("t4_data", {24'd0, bus.tx_data_o}, 32'h77);
    bus.req_valid_i = '0;
    wait_idle("t4", 8'h77);

    // Reset asserted during WAIT_DONE.
    model_auto = 0;
    bus.tx_ing_i = 1'b0;
    bus.req_data_i  = 32'h99000000;
    bus.req_valid_i = 4'b1000;
    #1;
    check_val("t5_ready", {28'd0, bus.req_ready_o}, 32'h8);
    tick();
    check_val("t5_txen", {31'd0, bus.txen_o}, 32'h1);
    bus.req_valid_i = '0;
    bus.tx_ing_i = 1'b1;
    tick();
    tick();
    tick();
    check_val("t5_busy", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_busy", {31'd0, busy}, 32'h0);
    check_val("t5_rst_txen", {31'd0, bus.txen_o}, 32'h0);
    check_val("t5_rst_grant", {30'd0, grant_id}, 32'h0);
    check_val("t5_rst_data", {24'd0, bus.tx_data_o}, 32'h0);
    check_val("t5_rst_err", {31'd0, start_err}, 32'h0);
    bus.req_data_i  = 32'h33000011;
    bus.req_valid_i = 4'b1001;
    bus.tx_ing_i = 1'b0;
    #1;
    check_val("t5_rst_ready", {28'd0, bus.req_ready_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("t5_prio_ready", {28'd0, bus.req_ready_o}, 32'h1);
    model_auto = 1;
    tick();
    check_val("t5_prio_grant", {30'd0, grant_id}, 32'h0);
    check_val("t5_prio_data", {24'd0, bus.tx_data_o}, 32'h11);
    bus.req_valid_i = '0;
    wait_idle("t5", 8'h11);

`ifdef UART_TX_ARB_LOCK_EN
    // Locked requester 1 sends three bytes before requester 2 is served.
    begin
      int   cnt1;
      int   exp_ids [4];
      exp_ids = '{1, 1, 1, 2};
      cnt1 = 0;
      apply_reset();
      model_auto = 1;
      bus.req_data_i  = 32'h00C0B000;
      bus.req_lock_i  = 4'b0010;
      bus.req_valid_i = 4'b0110;
      for (int g = 0; g < 4; g++) begin
        wait_txen("t6");
        check_val("t6_grant", {30'd0, grant_id}, exp_ids[g]);
        if (grant_id == 2'd1) begin
          cnt1++;
          if (cnt1 == 3) begin
            bus.req_valid_i[1] = 1'b0;
            bus.req_lock_i[1]  = 1'b0;
          end
        end else begin
          bus.req_valid_i[2] = 1'b0;
        end
        if (g < 3) tick();
      end
      wait_idle("t6", 8'hC0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
